// File: rtl/dataflow_queue_if.sv
// Token stream bundle between a producer/consumer pair and dataflow_queue.
// master = surrounding fabric, slave = the queue itself.
interface dataflow_queue_if #(
  parameter int N     = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          R_IN;
  logic [N-1:0]  D_IN;
  logic          STALL;
  logic          R_OUT;
  logic [N-1:0]  D_OUT;
  logic          FULL;
  logic          EMPTY;
  logic [CW-1:0] COUNT;

  modport master (
    output R_IN, D_IN, STALL,
    input  R_OUT, D_OUT, FULL, EMPTY, COUNT
  );

  modport slave (
    input  R_IN, D_IN, STALL,
    output R_OUT, D_OUT, FULL, EMPTY, COUNT
  );
endinterface

// File: rtl/dataflow_queue.sv
// Elastic FIFO stage after the merge node: buffers R/D tokens while the consumer stalls.
// Optional DFQ_OVERFLOW_FLAG_EN adds a sticky OVF output flagging dropped pushes.
module dataflow_queue #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
`ifdef DFQ_OVERFLOW_FLAG_EN
  output logic OVF,
`endif
  dataflow_queue_if.slave q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

  generate
    if (DEPTH < 2) begin : g_depth_check
      $error("dataflow_queue: DEPTH must be >= 2");
    end
  endgenerate

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          r_out;
  logic [N-1:0]  d_out;

  logic is_empty;
  logic is_full;
  logic pop;
  logic bypass;
  logic push_req;
  logic push;

  assign is_empty = (count == '0);
  assign is_full  = (count == COUNT_FULL);

  // Bypass only fires with empty storage, so FIFO ordering is never violated.
  always_comb begin
    pop      = 1'b0;
    bypass   = 1'b0;
    push_req = 1'b0;
    push     = 1'b0;
    if (EN) begin
      pop      = !q.STALL && !is_empty;
      bypass   = !q.STALL && is_empty && q.R_IN;
      push_req = q.R_IN && !bypass;
      push     = push_req && (!is_full || pop);
    end
  end

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out  <= 1'b0;
      d_out  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (EN) begin
      if (!q.STALL) begin
        if (pop) begin
          d_out  <= mem[rd_ptr];
          r_out  <= 1'b1;
          rd_ptr <= ptr_next(rd_ptr);
        end else if (bypass) begin
          d_out <= q.D_IN;
          r_out <= 1'b1;
        end else begin
          r_out <= 1'b0;
        end
      end
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem[wr_ptr] <= q.D_IN;
    end
  end

`ifdef DFQ_OVERFLOW_FLAG_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVF <= 1'b0;
    end else if (push_req && !push) begin
      OVF <= 1'b1;
    end
  end
`endif

  assign q.R_OUT = r_out;
  assign q.D_OUT = d_out;
  assign q.COUNT = count;
  assign q.FULL  = is_full;
  assign q.EMPTY = is_empty;
endmodule

// File: tb/tb_dataflow_queue.sv
// Directed self-checking bench for dataflow_queue (N=16, DEPTH=4).
module tb_dataflow_queue;
  logic CLK = 1'b0;
  logic RST;
  logic EN;
`ifdef DFQ_OVERFLOW_FLAG_EN
  logic OVF;
`endif

  int errors = 0;
  int checks = 0;

  dataflow_queue_if #(.N(16), .DEPTH(4)) qif ();

  dataflow_queue #(.N(16), .DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
`ifdef DFQ_OVERFLOW_FLAG_EN
    .OVF (OVF),
`endif
    .q   (qif)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic r, input logic [15:0] d,
                           input logic [2:0] cnt);
    check({tag, ".r_out"}, 32'(qif.R_OUT), 32'(r));
    check({tag, ".d_out"}, 32'(qif.D_OUT), 32'(d));
    check({tag, ".count"}, 32'(qif.COUNT), 32'(cnt));
    check({tag, ".full"},  32'(qif.FULL),  32'(cnt == 3'd4));
    check({tag, ".empty"}, 32'(qif.EMPTY), 32'(cnt == 3'd0));
  endtask

  task automatic drive(input logic r, input logic [15:0] d, input logic stall);
    qif.R_IN  = r;
    qif.D_IN  = d;
    qif.STALL = stall;
  endtask

  initial begin
    RST = 1'b1;
    EN  = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);

    // 1. reset / idle
    step();
    step();
    RST = 1'b0;
    EN  = 1'b1;
    step();
    check_out("reset_idle", 1'b0, 16'h0000, 3'd0);
`ifdef DFQ_OVERFLOW_FLAG_EN
    check("reset_ovf", 32'(OVF), 32'd0);
`endif

    // 2. bypass stream, 1-cycle latency
    drive(1'b1, 16'h0001, 1'b0); step(); check_out("bypass1", 1'b1, 16'h0001, 3'd0);
    drive(1'b1, 16'h0002, 1'b0); step(); check_out("bypass2", 1'b1, 16'h0002, 3'd0);
    drive(1'b1, 16'h0003, 1'b0); step(); check_out("bypass3", 1'b1, 16'h0003, 3'd0);

    // 3. fill while stalled, then overflow drop
    drive(1'b1, 16'h00A0, 1'b0); step(); check_out("preload", 1'b1, 16'h00A0, 3'd0);
    drive(1'b1, 16'h00A1, 1'b1); step(); check_out("fill1", 1'b1, 16'h00A0, 3'd1);
    drive(1'b1, 16'h00A2, 1'b1); step(); check_out("fill2", 1'b1, 16'h00A0, 3'd2);
    drive(1'b1, 16'h00A3, 1'b1); step(); check_out("fill3", 1'b1, 16'h00A0, 3'd3);
    drive(1'b1, 16'h00A4, 1'b1); step(); check_out("fill4", 1'b1, 16'h00A0, 3'd4);
`ifdef DFQ_OVERFLOW_FLAG_EN
    check("ovf_before_drop", 32'(OVF), 32'd0);
`endif
    drive(1'b1, 16'h00A5, 1'b1); step(); check_out("drop", 1'b1, 16'h00A0, 3'd4);
`ifdef DFQ_OVERFLOW_FLAG_EN
    check("ovf_set", 32'(OVF), 32'd1);
`endif

    // 4. push+pop at full keeps COUNT at 4
    drive(1'b1, 16'h0BEE, 1'b0); step(); check_out("full_pushpop", 1'b1, 16'h00A1, 3'd4);
    drive(1'b0, 16'h0000, 1'b0); step(); check_out("drain_a2", 1'b1, 16'h00A2, 3'd3);
    step(); check_out("drain_a3", 1'b1, 16'h00A3, 3'd2);

    // 5. EN gating at COUNT=2: token 0xDEAD must be lost
    EN = 1'b0;
    drive(1'b1, 16'hDEAD, 1'b0);
    step(); check_out("en_off1", 1'b1, 16'h00A3, 3'd2);
    step(); check_out("en_off2", 1'b1, 16'h00A3, 3'd2);
    step(); check_out("en_off3", 1'b1, 16'h00A3, 3'd2);
    EN = 1'b1;
    drive(1'b0, 16'h0000, 1'b0);
    step(); check_out("drain_a4", 1'b1, 16'h00A4, 3'd1);
    step(); check_out("drain_bee", 1'b1, 16'h0BEE, 3'd0);
    step(); check_out("idle_hold", 1'b0, 16'h0BEE, 3'd0);

    // 6. reset mid-operation with COUNT=3 and a valid output
    drive(1'b1, 16'h0011, 1'b0); step(); check_out("pre_rst_byp", 1'b1, 16'h0011, 3'd0);
    drive(1'b1, 16'h0012, 1'b1); step();
    drive(1'b1, 16'h0013, 1'b1); step();
    drive(1'b1, 16'h0014, 1'b1); step(); check_out("pre_rst", 1'b1, 16'h0011, 3'd3);
    RST = 1'b1;
    drive(1'b1, 16'h0099, 1'b0);
    step(); check_out("mid_reset", 1'b0, 16'h0000, 3'd0);
`ifdef DFQ_OVERFLOW_FLAG_EN
    check("ovf_cleared", 32'(OVF), 32'd0);
`endif
    RST = 1'b0;
    drive(1'b1, 16'h0055, 1'b0); step(); check_out("post_rst_byp", 1'b1, 16'h0055, 3'd0);
    drive(1'b0, 16'h0000, 1'b0); step(); check_out("post_rst_idle", 1'b0, 16'h0055, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
